// File: rtl/led_pattern_pkg.sv
// Shared types for the LED pattern generator: pattern select, scan/breathe direction, PWM width.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT   = 2'd0,
    MODE_SCAN    = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_OFF     = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam int PWM_WIDTH = 8;
  localparam logic [PWM_WIDTH-1:0] PWM_MAX = '1;

endpackage

// File: rtl/led_step_prescaler.sv
// Step prescaler: counts 0..STEP_CYCLES-1 and emits a registered one-cycle step_tick on each wrap.
// clear and reset restart the count from zero; pause holds the count and suppresses ticks.
module led_step_prescaler #(
  parameter int STEP_CYCLES = 3125000
) (
  input  logic clk_50mhz,
  input  logic rst_50mhz,
  input  logic clear,
  input  logic pause,
  output logic step_tick
);

  localparam int CW = $clog2(STEP_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_50mhz) begin
    if (rst_50mhz || clear) begin
      cnt       <= '0;
      step_tick <= 1'b0;
    end else if (pause) begin
      step_tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt       <= '0;
      step_tick <= 1'b1;
    end else begin
      cnt       <= cnt + 1'b1;
      step_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: count / scan / breathe / off patterns advanced by a step prescaler.
// Define LED_PATTERN_PWM_EN to build the PWM breathe engine; otherwise breathe is steady all-on.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int NUM_LEDS    = 8,
  parameter int STEP_CYCLES = 3125000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                clk_50mhz,
  input  logic                rst_50mhz,
  input  mode_t               mode,
  input  logic                pause,
  output logic [NUM_LEDS-1:0] led,
  output logic [NUM_LEDS-1:0] pattern,
  output logic                step_tick
);

  localparam int POS_W = $clog2(NUM_LEDS);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_LEDS - 1);

  mode_t               mode_q;
  logic                mode_chg;
  logic                advance;
  logic [NUM_LEDS-1:0] count_q, count_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  dir_t                dir_q, dir_d;
  logic [NUM_LEDS-1:0] pattern_d;

`ifdef LED_PATTERN_PWM_EN
  logic [PWM_WIDTH-1:0] pwm_cnt;
  logic [PWM_WIDTH-1:0] duty_q, duty_d;
  dir_t                 duty_dir_q, duty_dir_d;
`endif

  // A mode change restarts the step period so every pattern begins from its reset state.
  assign mode_chg = (mode != mode_q);
  assign advance  = step_tick & ~pause;

  led_step_prescaler #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_prescaler (
    .clk_50mhz(clk_50mhz),
    .rst_50mhz(rst_50mhz),
    .clear    (mode_chg),
    .pause    (pause),
    .step_tick(step_tick)
  );

  always_ff @(posedge clk_50mhz) begin
    if (rst_50mhz) begin
      mode_q  <= MODE_OFF;
      count_q <= '0;
      pos_q   <= '0;
      dir_q   <= DIR_UP;
      pattern <= '0;
      led     <= (ACTIVE_LOW != 0) ? '1 : '0;
    end else begin
      mode_q  <= mode;
      count_q <= count_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      pattern <= pattern_d;
      led     <= (ACTIVE_LOW != 0) ? ~pattern_d : pattern_d;
    end
  end

`ifdef LED_PATTERN_PWM_EN
  always_ff @(posedge clk_50mhz) begin
    if (rst_50mhz) begin
      pwm_cnt    <= '0;
      duty_q     <= '0;
      duty_dir_q <= DIR_UP;
    end else begin
      pwm_cnt    <= pwm_cnt + 1'b1;
      duty_q     <= duty_d;
      duty_dir_q <= duty_dir_d;
    end
  end
`endif

  always_comb begin
    count_d = count_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
`ifdef LED_PATTERN_PWM_EN
    duty_d     = duty_q;
    duty_dir_d = duty_dir_q;
`endif
    if (mode_chg) begin
      count_d = '0;
      pos_d   = '0;
      dir_d   = DIR_UP;
`ifdef LED_PATTERN_PWM_EN
      duty_d     = '0;
      duty_dir_d = DIR_UP;
`endif
    end else if (advance) begin
      case (mode_q)
        MODE_COUNT: count_d = count_q + 1'b1;
        MODE_SCAN: begin
          // Turn around at the ends so each end LED is lit for exactly one step.
          if (dir_q == DIR_UP) begin
            if (pos_q == POS_LAST) begin
              pos_d = POS_LAST - 1'b1;
              dir_d = DIR_DOWN;
            end else begin
              pos_d = pos_q + 1'b1;
            end
          end else begin
            if (pos_q == '0) begin
              pos_d = POS_W'(1);
              dir_d = DIR_UP;
            end else begin
              pos_d = pos_q - 1'b1;
            end
          end
        end
`ifdef LED_PATTERN_PWM_EN
        MODE_BREATHE: begin
          if (duty_dir_q == DIR_UP) begin
            if (duty_q == PWM_MAX) begin
              duty_d     = PWM_MAX - 1'b1;
              duty_dir_d = DIR_DOWN;
            end else begin
              duty_d = duty_q + 1'b1;
            end
          end else begin
            if (duty_q == '0) begin
              duty_d     = PWM_WIDTH'(1);
              duty_dir_d = DIR_UP;
            end else begin
              duty_d = duty_q - 1'b1;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Decoded from the incoming mode so a new mode shows its cleared state on the first cycle.
  always_comb begin
    pattern_d = '0;
    case (mode)
      MODE_COUNT: pattern_d = count_d;
      MODE_SCAN:  pattern_d = NUM_LEDS'(1) << pos_d;
`ifdef LED_PATTERN_PWM_EN
      MODE_BREATHE: pattern_d = (pwm_cnt < duty_d) ? '1 : '0;
`else
      MODE_BREATHE: pattern_d = '1;
`endif
      default: pattern_d = '0;
    endcase
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen (NUM_LEDS=4, STEP_CYCLES=4, active-low LEDs), both PWM builds.
module tb_led_pattern_gen;
  import led_pattern_pkg::*;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  mode_t        mode;
  logic         pause;
  logic [N-1:0] led;
  logic [N-1:0] pattern;
  logic         step_tick;

  int compared   = 0;
  int mismatched = 0;
  logic [N-1:0] exp_q[$];

  always #5 clk = ~clk;

  led_pattern_gen #(
    .NUM_LEDS   (N),
    .STEP_CYCLES(4),
    .ACTIVE_LOW (1)
  ) dut (
    .clk_50mhz(clk),
    .rst_50mhz(rst),
    .mode     (mode),
    .pause    (pause),
    .led      (led),
    .pattern  (pattern),
    .step_tick(step_tick)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tick(input string tag, input int budget, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (step_tick !== 1'b1 && cycles < budget);
    check(tag, 32'(step_tick), 32'd1);
  endtask

  // Expected pattern is queued before the tick and popped once the output register has updated.
  task automatic step(input string tag, input logic [N-1:0] exp, input int lat);
    int c;
    logic [N-1:0] e, ne;
    exp_q.push_back(exp);
    wait_tick($sformatf("%s_tick", tag), 12, c);
    if (lat != 0) check($sformatf("%s_lat", tag), c, lat);
    @(negedge clk);
    e  = exp_q.pop_front();
    ne = ~e;
    check($sformatf("%s_pat", tag), 32'(pattern), 32'(e));
    check($sformatf("%s_led", tag), 32'(led), 32'(ne));
  endtask

`ifdef LED_PATTERN_PWM_EN
  task automatic measure(input string tag, input int exp_on);
    int on_cnt, odd_cnt;
    on_cnt  = 0;
    odd_cnt = 0;
    repeat (256) begin
      @(negedge clk);
      if (led === 4'h0) on_cnt++;
      else if (led !== 4'hF) odd_cnt++;
    end
    check($sformatf("%s_on", tag), on_cnt, exp_on);
    check($sformatf("%s_odd", tag), odd_cnt, 0);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    logic [N-1:0] scan_exp[8];
    scan_exp = '{4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h2, 4'h4};

    rst   = 1'b1;
    mode  = MODE_OFF;
    pause = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_led", 32'(led), 32'hF);
    check("reset_pat", 32'(pattern), 32'h0);
    check("reset_tick", 32'(step_tick), 32'h0);
    rst = 1'b0;
    wait_tick("first_tick", 10, c);
    check("first_tick_lat", c, 4);

    // Binary count across the wrap
    mode = MODE_COUNT;
    @(negedge clk);
    check("count_clear_pat", 32'(pattern), 32'h0);
    for (int i = 1; i <= 17; i++) step($sformatf("count%0d", i), N'(i % 16), (i == 1) ? 4 : 0);

    // Pause freezes ticks and pattern, then resumes with the remaining prescaler count
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("pause_tick%0d", i), 32'(step_tick), 32'h0);
      check($sformatf("pause_pat%0d", i), 32'(pattern), 32'h1);
    end
    pause = 1'b0;
    step("resume", 4'h2, 3);

    // Scan from reset position
    mode = MODE_SCAN;
    @(negedge clk);
    check("scan_clear_pat", 32'(pattern), 32'h1);
    for (int i = 0; i < 8; i++) step($sformatf("scan%0d", i), scan_exp[i], (i == 0) ? 4 : 0);

    // Mode change in the same cycle as a tick: the clear wins
    mode = MODE_COUNT;
    @(negedge clk);
    check("count2_clear_pat", 32'(pattern), 32'h0);
    step("count2_a", 4'h1, 4);
    step("count2_b", 4'h2, 0);
    wait_tick("coin_tick", 12, c);
    mode = MODE_SCAN;
    @(negedge clk);
    check("coin_pat", 32'(pattern), 32'h1);
    check("coin_led", 32'(led), 32'hE);
    step("coin_next", 4'h2, 4);

    // Reset in the middle of a scan step
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_pat", 32'(pattern), 32'h0);
    check("midrst_led", 32'(led), 32'hF);
    check("midrst_tick", 32'(step_tick), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_pat", 32'(pattern), 32'h1);
    step("postrst_step", 4'h2, 4);

    mode = MODE_BREATHE;
    @(negedge clk);
`ifdef LED_PATTERN_PWM_EN
    check("breathe_duty0_pat", 32'(pattern), 32'h0);
    for (int i = 0; i < 128; i++) wait_tick($sformatf("br_up%0d", i), 12, c);
    @(negedge clk);
    pause = 1'b1;
    measure("duty128", 128);
    pause = 1'b0;
    for (int i = 128; i < 255; i++) wait_tick($sformatf("br_up%0d", i), 12, c);
    @(negedge clk);
    pause = 1'b1;
    measure("duty255", 255);
    pause = 1'b0;
    wait_tick("br_turn", 12, c);
    @(negedge clk);
    pause = 1'b1;
    measure("duty254", 254);
    pause = 1'b0;
`else
    check("breathe_pat", 32'(pattern), 32'hF);
    for (int i = 0; i < 3; i++) step($sformatf("breathe%0d", i), 4'hF, (i == 0) ? 4 : 0);
`endif

    mode = MODE_OFF;
    @(negedge clk);
    check("off_pat", 32'(pattern), 32'h0);
    step("off_step", 4'h0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
